// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
// Bundles the two requester ports and the memory command/response lines
// shared by the data-memory arbiter.
//   slave  modport : the arbiter side (takes requests and m_rdata, drives
//                    grants, read responses and memory commands)
//   master modport : the environment side (requesters plus memory)
// Ports per requester: req, we, addr, wdata in; gnt, rvalid, rdata out.
// Memory lines: m_read, m_write, m_addr, m_wdata out; m_rdata in.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  m_rdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output m_read, m_write, m_addr, m_wdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output m_rdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares a single-ported pipelined data memory between the CPU MEM stage
// (port 0, priority) and a secondary master (port 1). One access is granted
// per cycle, combinationally. Port 1 is guaranteed service: after
// STARVE_LIMIT consecutive denied cycles it pre-empts port 0 for one cycle.
// The single outstanding read is tracked so the memory's registered read
// data is steered back to the port that issued it.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - dmem_arbiter_if.slave: requester ports p0/p1 and memory lines
module dmem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {IDLE, RD_PEND} state_t;

  state_t      state_q, state_d;
  logic        rd_owner_q, rd_owner_d;   // 0 = port 0, 1 = port 1
  logic [3:0]  starve_cnt_q, starve_cnt_d;

  logic        p0_gnt, p1_gnt;
  logic        m_read, m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  // Grant and command mux. Grants are suppressed during reset so nothing is
  // committed to memory while the block is held in reset.
  always_comb begin
    p0_gnt  = 1'b0;
    p1_gnt  = 1'b0;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (!rst) begin
      if (bus.p1_req && (starve_cnt_q == LIMIT || !bus.p0_req)) begin
        p1_gnt  = 1'b1;
        m_read  = !bus.p1_we;
        m_write = bus.p1_we;
        m_addr  = bus.p1_addr;
        m_wdata = bus.p1_wdata;
      end else if (bus.p0_req) begin
        p0_gnt  = 1'b1;
        m_read  = !bus.p0_we;
        m_write = bus.p0_we;
        m_addr  = bus.p0_addr;
        m_wdata = bus.p0_wdata;
      end
    end
  end

  // Starvation counter: counts consecutive cycles port 1 waits. A withdrawn
  // request or a grant restarts the count.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.p1_req || p1_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  // Read tracking: every issued read lands in RD_PEND for exactly the next
  // cycle; a back-to-back read simply refreshes the owner.
  always_comb begin
    state_d    = state_q;
    rd_owner_d = rd_owner_q;
    if (m_read) begin
      state_d    = RD_PEND;
      rd_owner_d = p1_gnt;
    end else begin
      state_d    = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_owner_q   <= 1'b0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  logic p0_rvalid, p1_rvalid;

  always_comb begin
    p0_rvalid = (state_q == RD_PEND) && !rd_owner_q;
    p1_rvalid = (state_q == RD_PEND) &&  rd_owner_q;
  end

  assign bus.p0_gnt    = p0_gnt;
  assign bus.p1_gnt    = p1_gnt;
  assign bus.p0_rvalid = p0_rvalid;
  assign bus.p1_rvalid = p1_rvalid;
  // m_rdata is already registered by the memory; only the owner sees it.
  assign bus.p0_rdata  = p0_rvalid ? bus.m_rdata : '0;
  assign bus.p1_rdata  = p1_rvalid ? bus.m_rdata : '0;
  assign bus.m_read    = m_read;
  assign bus.m_write   = m_write;
  assign bus.m_addr    = m_addr;
  assign bus.m_wdata   = m_wdata;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported pipelined data memory between the CPU MEM stage (port 0) and a secondary master such as a debug/DMA engine (port 1). It grants one request per cycle with port 0 priority, guarantees port 1 service through a starvation counter, and drives the memory command lines. It also tracks the one outstanding read so the registered read data is returned to the requester that issued it.

## Interface
- ADDR_W, 64, address width; forwarded unchanged (memory decodes word index addr[9:3])
- DATA_W, 64, data width
- STARVE_LIMIT, 4, consecutive denied cycles after which port 1 pre-empts port 0 (range 1..15)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_req / p1_req  in  1  request valid; held with payload stable until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  byte address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  request accepted this cycle (combinational)
- p0_rvalid / p1_rvalid  out  1  read data valid for this port (registered)
- p0_rdata / p1_rdata  out  DATA_W  read data; 0 when the port's rvalid is low
- m_read  out  1  memory read strobe
- m_write  out  1  memory write strobe
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory registered read data (valid the cycle after m_read)

## Operation
- Grant rule per cycle, combinational:
  - p1 wins if p1_req && (starve_cnt == STARVE_LIMIT || !p0_req).
  - Otherwise p0 wins if p0_req.
  - At most one gnt is high. No gnt while rst is high.
- Command mux:
  - Granted port drives m_addr/m_wdata.
  - m_read = gnt && !we; m_write = gnt && we.
  - With no grant: m_read = m_write = 0, m_addr = m_wdata = 0.
- Starvation counter starve_cnt, 4 bits:
  - Cleared if p1_req is low or p1_gnt is high.
  - Else increments on each cycle p1_req && !p1_gnt, saturating at STARVE_LIMIT.
- Read tracking, two states IDLE/RD_PEND:
  - At the edge where m_read is high: enter RD_PEND and latch rd_owner = granted port.
  - Next cycle: assert rvalid of rd_owner, that port's rdata = m_rdata, other port rdata = 0.
  - Leave RD_PEND at the following edge unless a new read is issued. Back-to-back reads stay in RD_PEND with the updated owner.
- Writes produce no response. A write is committed at the edge where its gnt is high.
- Requester contract: deasserting req without gnt is legal (request withdrawn). Changing payload while req is high and ungranted is illegal.

## Timing
- Reset values:
  - p0_gnt, p1_gnt, p0_rvalid, p1_rvalid = 0
  - p0_rdata, p1_rdata = 0
  - m_read, m_write = 0; m_addr, m_wdata = 0
  - starve_cnt = 0, state IDLE, rd_owner = 0
- Grant latency: 0 cycles (same cycle as req).
- Read latency: rvalid exactly 1 cycle after the grant cycle.
- Throughput: one access per cycle, reads and writes freely interleaved, no bubbles.
- Read grant in cycle N followed by a write grant to the same word in cycle N+1: rdata in N+1 carries the old value.
- Reset asserted mid-operation: any pending read is dropped and no rvalid is produced after reset deasserts. The counter clears immediately (asynchronous).
- STARVE_LIMIT reached with p0_req and p1_req both high: p1 granted for exactly one cycle, counter clears, then p0 priority resumes.

## Test plan
- Reset then idle: all outputs 0. Assert rst mid-read (grant in cycle N, rst in N+1) -> no rvalid on either port afterward.
- p0 write addr 0x10 data 0xDEADBEEF, next cycle p0 read 0x10 -> p0_gnt both cycles; p0_rvalid one cycle later with p0_rdata 0xDEADBEEF; p1_rvalid stays 0.
- p1 alone: write 0x20 = 0x1234, then read 0x20 -> p1_gnt same cycle each time; p1_rvalid with 0x1234 one cycle after the read grant.
- Both req continuously, STARVE_LIMIT=4 -> p0 granted 4 cycles, p1 granted on the 5th cycle, pattern repeats every 5 cycles; starve_cnt never exceeds 4.
- Back-to-back reads p0 @0x08, p1 @0x18 (forced via starvation) -> rvalid alternates to the correct owner on consecutive cycles with the correct data; non-owner rdata = 0.
- p1_req withdrawn after 2 denied cycles, reasserted -> counter restarts from 0, so p1 gets its forced grant only after 4 further denied cycles.
